// File: rtl/jpeg_pkg.sv
// jpeg_pkg: constants shared by the JPEG zigzag stages (encoder and decoder side).
//   ZZ2RASTER[z] : raster address (row*8+col) of zigzag index z
//   RASTER2ZZ[a] : zigzag index of raster address a (inverse of ZZ2RASTER)
//   BLK_WORDS    : words per 8x8 block
//   COEFS_PER_WORD : coefficients packed per word
package jpeg_pkg;

  localparam int BLK_WORDS      = 8;
  localparam int COEFS_PER_WORD = 8;

  localparam logic [5:0] ZZ2RASTER [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] RASTER2ZZ [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

endpackage

// File: rtl/inverse_zigzag_buffer_zz_bank.sv
// zz_bank: one 64-coefficient block store.
//   clk     : rising-edge clock
//   wr_en   : write one zigzag word this cycle
//   wr_word : zigzag word index k (carries indices 8k..8k+7)
//   wr_data : 8 coefficients, index 8k+j at the j-th slot from the MSB
//   rd_row  : raster row to present
//   rd_data : raster row rd_row, column 0 at the MSB slot
// Contents are not reset; the owner tracks validity with its full flag.
module zz_bank
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 8,
  localparam int WORD_W = COEFS_PER_WORD * COEF_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [2:0]        wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [2:0]        rd_row,
  output logic [WORD_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem [64];

  // Scatter: each of the 8 coefficients goes to its own raster address,
  // so a whole word lands in one cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < COEFS_PER_WORD; j++) begin
        mem[ZZ2RASTER[{wr_word, 3'(j)}]] <=
          wr_data[(COEFS_PER_WORD-j)*COEF_W-1 -: COEF_W];
      end
    end
  end

  for (genvar c = 0; c < COEFS_PER_WORD; c++) begin : g_col
    assign rd_data[(COEFS_PER_WORD-c)*COEF_W-1 -: COEF_W] = mem[{rd_row, 3'(c)}];
  end

endmodule

// File: rtl/inverse_zigzag_buffer.sv
// inverse_zigzag_buffer: zigzag-ordered coefficient words in, raster rows out.
// Two ping-pong banks so one block fills while the other drains.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_data = zigzag word
//   out_valid/out_ready : output handshake, out_data = raster row out_row
//   out_last            : high with row 7 of a block
module inverse_zigzag_buffer
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 8,
  localparam int WORD_W = COEFS_PER_WORD * COEF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [2:0]        out_row,
  output logic              out_last
);

  logic [1:0]             full;
  logic                   wr_bank, rd_bank;
  logic [2:0]             wr_word, rd_row;
  logic                   in_fire, out_fire;
  logic [1:0][WORD_W-1:0] bank_rd;

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zz_bank #(.COEF_W(COEF_W)) u_bank (
      .clk     (clk),
      .wr_en   (in_fire && (wr_bank == 1'(b))),
      .wr_word (wr_word),
      .wr_data (in_data),
      .rd_row  (rd_row),
      .rd_data (bank_rd[b])
    );
  end

  // Read port follows the pointers only, so data holds while stalled.
  assign out_data = bank_rd[rd_bank];
  assign out_row  = rd_row;
  assign out_last = (rd_row == 3'd7);

  // Set and clear always hit different banks (write side only sees a
  // non-full bank, read side only a full one), so both may apply at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_word <= '0;
      rd_row  <= '0;
    end else begin
      if (in_fire) begin
        wr_word <= wr_word + 3'd1;
        if (wr_word == 3'd7) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (out_fire) begin
        rd_row <= rd_row + 3'd1;
        if (rd_row == 3'd7) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_inverse_zigzag_buffer.sv
module tb_inverse_zigzag_buffer;
  import jpeg_pkg::*;

  logic        clk = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [63:0] out_data;
  logic [2:0]  out_row;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  inverse_zigzag_buffer #(.COEF_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Coefficient value at zigzag index z of a block; seed<0 marks the
  // signed-value block (0xFF at index 0, 0x80 at index 63).
  function automatic logic [7:0] coef(int seed, int z);
    if (seed < 0) return (z == 63) ? 8'h80 : ((z == 0) ? 8'hFF : 8'(z));
    return 8'(z + seed);
  endfunction

  function automatic logic [63:0] zz_word(int seed, int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[(8-j)*8-1 -: 8] = coef(seed, 8*k + j);
    return w;
  endfunction

  function automatic logic [63:0] exp_row(int seed, int r);
    logic [63:0] w;
    for (int c = 0; c < 8; c++) w[(8-c)*8-1 -: 8] = coef(seed, int'(RASTER2ZZ[8*r + c]));
    return w;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 0; out_ready = 0; reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_row !== 3'd0) begin errors++; $display("FAIL reset_out_row got=%0d want=0", out_row); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
  endtask

  task automatic test_single_block();
    logic [63:0] row0, row7;
    row0 = {8'd0, 8'd1, 8'd5, 8'd6, 8'd14, 8'd15, 8'd27, 8'd28};
    row7 = {8'd35, 8'd36, 8'd48, 8'd49, 8'd57, 8'd58, 8'd62, 8'd63};
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1; in_data = zz_word(0, k);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready k=%0d got=%b want=1", k, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid k=%0d got=%b want=0", k, out_valid); end
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid r=%0d got=%b want=1", r, out_valid); end
      checks++; if (out_row !== 3'(r)) begin errors++; $display("FAIL single_row got=%0d want=%0d", out_row, r); end
      checks++; if (out_last !== (r == 7)) begin errors++; $display("FAIL single_last r=%0d got=%b", r, out_last); end
      checks++; if (out_data !== exp_row(0, r)) begin errors++; $display("FAIL single_data r=%0d got=%h want=%h", r, out_data, exp_row(0, r)); end
      if (r == 0) begin
        checks++; if (out_data !== row0) begin errors++; $display("FAIL single_row0 got=%h want=%h", out_data, row0); end
      end
      if (r == 7) begin
        checks++; if (out_data !== row7) begin errors++; $display("FAIL single_row7 got=%h want=%h", out_data, row7); end
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int wi = 0, ri = 0;
    bit started = 0;
    out_ready = 1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      if (wi < 32) begin
        in_valid = 1; in_data = zz_word(40*(wi/8) + 3, wi % 8);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready wi=%0d got=%b want=1", wi, in_ready); end
        if (in_ready === 1'b1) wi++;
      end else in_valid = 0;
      if (started && ri < 32) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble ri=%0d got=%b want=1", ri, out_valid); end
      end
      if (out_valid === 1'b1) begin
        started = 1;
        if (ri < 32) begin
          checks++; if (out_row !== 3'(ri % 8)) begin errors++; $display("FAIL b2b_row ri=%0d got=%0d", ri, out_row); end
          checks++; if (out_last !== (ri % 8 == 7)) begin errors++; $display("FAIL b2b_last ri=%0d got=%b", ri, out_last); end
          checks++; if (out_data !== exp_row(40*(ri/8) + 3, ri % 8)) begin errors++; $display("FAIL b2b_data ri=%0d got=%h want=%h", ri, out_data, exp_row(40*(ri/8) + 3, ri % 8)); end
        end
        ri++;
      end
    end
    checks++; if (ri != 32) begin errors++; $display("FAIL b2b_row_count got=%0d want=32", ri); end
  endtask

  task automatic test_backpressure();
    int seeds [3] = '{50, 100, 150};
    int wi = 0, ri = 8;
    out_ready = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      in_valid = 1; in_data = zz_word(seeds[wi/8], wi % 8);
      if (in_ready === 1'b1) wi++;
    end
    checks++; if (wi != 16) begin errors++; $display("FAIL bp_accepted got=%0d want=16", wi); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got=%b want=0", in_ready); end
    out_ready = 1;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drain r=%0d got=%b want=0", r, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_row !== 3'(r)) begin errors++; $display("FAIL bp_row got=%b/%0d want=1/%0d", out_valid, out_row, r); end
      checks++; if (out_data !== exp_row(seeds[0], r)) begin errors++; $display("FAIL bp_data r=%0d got=%h want=%h", r, out_data, exp_row(seeds[0], r)); end
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise got=%b want=1", in_ready); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (wi < 24) begin
        in_valid = 1; in_data = zz_word(seeds[wi/8], wi % 8);
        if (in_ready === 1'b1) wi++;
      end else in_valid = 0;
      if (out_valid === 1'b1 && ri < 24) begin
        checks++; if (out_row !== 3'(ri % 8) || out_data !== exp_row(seeds[ri/8], ri % 8)) begin
          errors++; $display("FAIL bp_tail ri=%0d got=%0d/%h want=%0d/%h", ri, out_row, out_data, ri % 8, exp_row(seeds[ri/8], ri % 8));
        end
        ri++;
      end
    end
    in_valid = 0;
    checks++; if (ri != 24 || wi != 24) begin errors++; $display("FAIL bp_counts got=%0d/%0d want=24/24", ri, wi); end
  endtask

  task automatic test_stall();
    out_ready = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1; in_data = zz_word(7, k);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready k=%0d got=%b want=1", k, in_ready); end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_row !== 3'(r)) begin errors++; $display("FAIL stall_row got=%b/%0d want=1/%0d", out_valid, out_row, r); end
      checks++; if (out_data !== exp_row(7, r)) begin errors++; $display("FAIL stall_data r=%0d got=%h want=%h", r, out_data, exp_row(7, r)); end
      if (r == 3) begin
        out_ready = 0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++; if (out_valid !== 1'b1 || out_row !== 3'd3 || out_data !== exp_row(7, 3)) begin
            errors++; $display("FAIL stall_hold s=%0d got=%b/%0d/%h want=1/3/%h", s, out_valid, out_row, out_data, exp_row(7, 3));
          end
        end
        out_ready = 1;
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1; in_data = zz_word(60, k);
    end
    @(negedge clk);
    in_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    checks++; if (out_row !== 3'd0) begin errors++; $display("FAIL rmid_out_row got=%0d want=0", out_row); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = 1; in_data = zz_word(70, k);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early_valid k=%0d got=%b want=0", k, out_valid); end
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      in_valid = 0;
      checks++; if (out_valid !== 1'b1 || out_row !== 3'(r) || out_data !== exp_row(70, r)) begin
        errors++; $display("FAIL rmid_row r=%0d got=%b/%0d/%h want=1/%0d/%h", r, out_valid, out_row, out_data, r, exp_row(70, r));
      end
    end
  endtask

  task automatic test_negative();
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1; in_data = zz_word(-1, k);
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      in_valid = 0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_row(-1, r)) begin
        errors++; $display("FAIL neg_row r=%0d got=%b/%h want=1/%h", r, out_valid, out_data, exp_row(-1, r));
      end
      if (r == 0) begin
        checks++; if (out_data[63:56] !== 8'hFF) begin errors++; $display("FAIL neg_r0c0 got=%h want=ff", out_data[63:56]); end
      end
      if (r == 7) begin
        checks++; if (out_data[7:0] !== 8'h80) begin errors++; $display("FAIL neg_r7c7 got=%h want=80", out_data[7:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_negative();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inverse_zigzag_buffer.md
Name: inverse_zigzag_buffer

Overview:
- Decoder-side counterpart of the encoder's zigzag stage.
- Accepts quantized coefficient words in JPEG zigzag order, 8 coefficients per word and 8 words per 8x8 block.
- Scatters each coefficient into raster position and emits the block as 8 raster rows, one row per word, for the dequantizer and IDCT.
- Uses two ping-pong banks so one block can be filled while the other drains, with valid/ready flow control on both sides.

Parameters:
- COEF_W, 8: signed coefficient width in bits.
- WORD_W, 8*COEF_W: input and output word width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a valid zigzag word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WORD_W  zigzag word k carries zigzag indices 8k..8k+7, MSB-first: index 8k+j sits at bits [(8-j)*COEF_W-1 -: COEF_W].
- out_valid  out  1  out_data holds a valid raster row.
- out_ready  in  1  downstream accepts the row this cycle.
- out_data  out  WORD_W  raster row r, columns 0..7, MSB-first with the same packing as in_data.
- out_row  out  3  row index r of out_data.
- out_last  out  1  high with row 7 of a block.

Behaviour:
- Handshakes:
  - An input transfer happens when in_valid & in_ready; an output transfer when out_valid & out_ready.
  - out_data, out_row and out_last hold stable while out_valid & ~out_ready.
- Storage: two banks, 64 x COEF_W registers each. Each bank has a full flag.
- Write side:
  - wr_bank pointer and a 3-bit wr_word counter.
  - in_ready = ~full[wr_bank].
  - On each input transfer, coefficient zigzag index z = 8*wr_word + j is written to raster address ZZ2RASTER[z], then wr_word increments.
  - On the transfer with wr_word==7: set full[wr_bank], toggle wr_bank, wrap wr_word to 0.
- Read side:
  - rd_bank pointer and a 3-bit rd_row counter.
  - out_valid = full[rd_bank].
  - out_data is combinational from bank[rd_bank] row rd_row; out_row = rd_row; out_last = (rd_row==7).
  - On each output transfer rd_row increments. On the transfer with rd_row==7: clear full[rd_bank], toggle rd_bank, wrap rd_row to 0.
- Latency and throughput:
  - out_valid rises the cycle after the 8th word of a block is accepted.
  - Sustained throughput is 1 word/cycle in and 1 row/cycle out.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other in the same cycle is legal; both take effect.
  - Set and clear never target the same bank in the same cycle, because write only touches a non-full bank and read only touches a full bank.
- Full/empty boundaries:
  - Both banks full: in_ready=0, and the input word is not consumed.
  - Both banks empty: out_valid=0.
- Reset (synchronous, active-high) clears full[1:0], wr_bank, rd_bank, wr_word and rd_row.
  - After reset: in_ready=1, out_valid=0, out_row=0, out_last=0.
  - Bank contents are not reset. out_data is don't-care while out_valid=0.
- Reset mid-block: a partially written or partially read block is discarded. The next accepted word is treated as word 0 of a new block into bank 0.
- in_data arithmetic: pure data movement, no sign extension and no modification of coefficient values.
- ZZ2RASTER is the standard JPEG order:
  - 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,
  - 12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
  - 35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
  - 58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63

Decomposition:
- Shared package jpeg_pkg:
  - the ZZ2RASTER constant array (64 x 6 bits) and its inverse RASTER2ZZ, used by the bench and by any future encoder-side rewrite;
  - BLK_WORDS=8, COEFS_PER_WORD=8.
- One natural sub-module: zz_bank.
  - One 64-coefficient bank with an 8-coefficient scatter-write port (word index plus data) and a row read port.
  - Instantiated twice.
  - Pointers and full flags stay in the top.

Test Plan:
- Single block, input coefficient value = zigzag index (COEF_W=8), out_ready=1 -> 8 rows with out_valid starting the cycle after word 7.
  - Row 0 = 0,1,5,6,14,15,27,28.
  - Row 7 = 35,36,48,49,57,58,62,63.
  - out_last high only on row 7.
- Four back-to-back blocks with in_valid=1 and out_ready=1 throughout -> in_ready never drops, 32 rows emitted with no bubbles, and each block's rows match RASTER2ZZ of its data.
- out_ready=0, 3 blocks offered -> in_ready falls after exactly 16 accepted words. Raising out_ready -> block 0 drains, and in_ready rises the cycle after the row 7 transfer.
- Stall mid-drain (out_ready low for 5 cycles at row 3) -> out_data and out_row=3 hold stable, with no lost or duplicated rows.
- Reset asserted after 5 words of a block -> next cycle in_ready=1 and out_valid=0. A fresh 8-word block then emits correctly from bank 0.
- Negative coefficients (e.g. 8'h80 at zigzag index 63) -> appear unchanged at row 7, column 7.
